// File: rtl/regfile_multiport_if.sv
// Bus bundle between decode/issue/ROB (master) and the multi-port register file (slave).
interface regfile_multiport_if #(
   parameter int unsigned NREG  = 32,
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 4,
   parameter int unsigned NRD   = 4,
   parameter int unsigned NLK   = 2,
   parameter int unsigned NCM   = 2
);
   localparam int unsigned RW = $clog2(NREG);

   logic                  ready;
   logic                  clear;
   logic [NRD-1:0]        rd_query;
   logic [NRD*RW-1:0]     rd_pos;
   logic [NRD-1:0]        rd_flag;
   logic [NRD-1:0]        rd_type;
   logic [NRD*XLEN-1:0]   rd_val;
   logic [NLK-1:0]        lock;
   logic [NLK*RW-1:0]     lock_rd;
   logic [NLK*TAG_W-1:0]  lock_robpos;
   logic [NCM-1:0]        unlock;
   logic [NCM*RW-1:0]     unlock_rd;
   logic [NCM*TAG_W-1:0]  unlock_robpos;
   logic [NCM*XLEN-1:0]   unlock_val;
   logic [RW:0]           busy_cnt;

   modport master (
      output ready, clear, rd_query, rd_pos,
      output lock, lock_rd, lock_robpos,
      output unlock, unlock_rd, unlock_robpos, unlock_val,
      input  rd_flag, rd_type, rd_val, busy_cnt
   );

   modport slave (
      input  ready, clear, rd_query, rd_pos,
      input  lock, lock_rd, lock_robpos,
      input  unlock, unlock_rd, unlock_robpos, unlock_val,
      output rd_flag, rd_type, rd_val, busy_cnt
   );
endinterface

// File: rtl/regfile_multiport.sv
// Multi-port architectural register file with busy/rename-tag tracking.
// Optional REGFILE_BYPASS_EN forwards same-cycle commit data to reads of busy registers.
module regfile_multiport #(
   parameter int unsigned NREG  = 32,
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 4,
   parameter int unsigned NRD   = 4,
   parameter int unsigned NLK   = 2,
   parameter int unsigned NCM   = 2
) (
   input logic               clk,
   input logic               reset,
   regfile_multiport_if.slave bus
);
   localparam int unsigned RW = $clog2(NREG);
   localparam int unsigned CW = RW + 1;

   logic [XLEN-1:0]  val_q [NREG];
   logic [XLEN-1:0]  val_d [NREG];
   logic [TAG_W-1:0] qi_q  [NREG];
   logic [TAG_W-1:0] qi_d  [NREG];
   logic [NREG-1:0]  busy_q;
   logic [NREG-1:0]  busy_d;
   logic [CW-1:0]    busy_cnt_q;
   logic [CW-1:0]    busy_cnt_d;
   logic [RW-1:0]    ur;
   logic [RW-1:0]    lr;
   logic [RW-1:0]    rp;
   logic [NRD-1:0]   rd_type_c;
   logic [NRD*XLEN-1:0] rd_val_c;

   // Next state: unlocks first (pre-edge tag match), then locks so a lock wins busy/qi.
   always_comb begin
      val_d  = val_q;
      qi_d   = qi_q;
      busy_d = busy_q;
      ur     = '0;
      lr     = '0;
      if (bus.clear) begin
         busy_d = '0;
         for (int unsigned i = 0; i < NREG; i++) qi_d[i] = '0;
         for (int unsigned c = 0; c < NCM; c++) begin
            ur = bus.unlock_rd[c*RW +: RW];
            if (bus.unlock[c] && ur != '0) val_d[ur] = bus.unlock_val[c*XLEN +: XLEN];
         end
      end else if (bus.ready) begin
         for (int unsigned c = 0; c < NCM; c++) begin
            ur = bus.unlock_rd[c*RW +: RW];
            if (bus.unlock[c] && ur != '0) begin
               val_d[ur] = bus.unlock_val[c*XLEN +: XLEN];
               if (busy_q[ur] && qi_q[ur] == bus.unlock_robpos[c*TAG_W +: TAG_W])
                  busy_d[ur] = 1'b0;
            end
         end
         for (int unsigned l = 0; l < NLK; l++) begin
            lr = bus.lock_rd[l*RW +: RW];
            if (bus.lock[l] && lr != '0) begin
               busy_d[lr] = 1'b1;
               qi_d[lr]   = bus.lock_robpos[l*TAG_W +: TAG_W];
            end
         end
      end
      busy_cnt_d = '0;
      for (int unsigned i = 0; i < NREG; i++) busy_cnt_d = busy_cnt_d + CW'(busy_d[i]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            val_q[i] <= '0;
            qi_q[i]  <= '0;
         end
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         val_q      <= val_d;
         qi_q       <= qi_d;
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   // Combinational read ports over pre-edge state.
   always_comb begin
      rd_type_c = '0;
      rd_val_c  = '0;
      rp        = '0;
      for (int unsigned r = 0; r < NRD; r++) begin
         rp = bus.rd_pos[r*RW +: RW];
         if (bus.rd_query[r] && rp != '0) begin
            if (busy_q[rp]) begin
               rd_type_c[r]             = 1'b1;
               rd_val_c[r*XLEN +: XLEN] = XLEN'(qi_q[rp]);
`ifdef REGFILE_BYPASS_EN
               for (int unsigned c = 0; c < NCM; c++) begin
                  if (bus.unlock[c] && bus.unlock_robpos[c*TAG_W +: TAG_W] == qi_q[rp]) begin
                     rd_type_c[r]             = 1'b0;
                     rd_val_c[r*XLEN +: XLEN] = bus.unlock_val[c*XLEN +: XLEN];
                  end
               end
`endif
            end else begin
               rd_val_c[r*XLEN +: XLEN] = val_q[rp];
            end
         end
      end
   end

   assign bus.rd_flag  = bus.rd_query;
   assign bus.rd_type  = rd_type_c;
   assign bus.rd_val   = rd_val_c;
   assign bus.busy_cnt = busy_cnt_q;
endmodule
